// File: rtl/servo_pkg.sv
// Shared constants, tick conversion and state type for the multi-channel servo PWM.
// Optional slew limiting is selected with the SERVO_RAMP_EN macro.
package servo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned us2ticks(
        input int unsigned us,
        input int unsigned clk_hz
    );
        return us * (clk_hz / 1_000_000);
    endfunction

    localparam int unsigned DEF_CLK_HZ       = 50_000_000;
    localparam int unsigned DEF_PERIOD_TICKS = us2ticks(20000, DEF_CLK_HZ);
    localparam int unsigned DEF_MIN_TICKS    = us2ticks(1000, DEF_CLK_HZ);
    localparam int unsigned DEF_MAX_TICKS    = us2ticks(2000, DEF_CLK_HZ);

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: position select to width, frame-boundary width update, compare.
// With SERVO_RAMP_EN defined the width slews by at most STEP_TICKS per frame.
module servo_pwm_chan
    import servo_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned MIN_TICKS  = DEF_MIN_TICKS,
`ifdef SERVO_RAMP_EN
    parameter int unsigned STEP_TICKS = 5000,
`endif
    parameter int unsigned MAX_TICKS  = DEF_MAX_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             boundary,
    input  logic [CNT_W-1:0] count,
    input  logic [SEL_W-1:0] sel,
    output logic             servo,
    output logic             busy
);

    localparam int unsigned NPOS = 2 ** SEL_W;
    localparam int unsigned SPAN = MAX_TICKS - MIN_TICKS;
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_TICKS);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] cur_d;

    // multiply first so every position lands on its exact share of the span
    always_comb begin
        target = CNT_W'((32'(sel) * SPAN) / (NPOS - 1) + MIN_TICKS);
    end

`ifdef SERVO_RAMP_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(STEP_TICKS);

    always_comb begin
        cur_d = target;
        if (target > cur_q) begin
            if ((target - cur_q) > STEP) begin
                cur_d = cur_q + STEP;
            end
        end else if ((cur_q - target) > STEP) begin
            cur_d = cur_q - STEP;
        end
    end
`else
    always_comb begin
        cur_d = target;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= MIN_W;
            servo <= 1'b0;
            busy  <= 1'b0;
        end else begin
            if (boundary) begin
                cur_q <= cur_d;
            end
            servo <= run && (count < cur_q);
            busy  <= (cur_q != target);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM: shared frame counter and run state, one channel per output.
// Define SERVO_RAMP_EN to slew-limit width changes to STEP_US per frame.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned STEP_US   = 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [CHANNELS*SEL_W-1:0] sel,
    output logic [CHANNELS-1:0]       servo,
    output logic                      frame_start,
    output logic [CHANNELS-1:0]       busy
);

    localparam int unsigned PERIOD_TICKS = us2ticks(PERIOD_US, CLK_HZ);
    localparam int unsigned MIN_TICKS    = us2ticks(MIN_US, CLK_HZ);
    localparam int unsigned MAX_TICKS    = us2ticks(MAX_US, CLK_HZ);
    localparam int unsigned CNT_W        = $clog2(PERIOD_TICKS);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD_TICKS - 1);

    generate
        if (MIN_TICKS == 0 || MAX_TICKS >= PERIOD_TICKS || MAX_TICKS < MIN_TICKS) begin : g_bad_cfg
            $error("servo_pwm_multi: need 0 < MIN_TICKS <= MAX_TICKS < PERIOD_TICKS");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fs_d;
    logic             run;
    logic             boundary;

    assign run      = (state_q == RUN) && enable;
    assign boundary = run && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        fs_d = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_start <= fs_d;
        end
    end

`ifndef SERVO_RAMP_EN
    // step size only matters when slewing is built in
    localparam int unsigned unused_step_us = STEP_US;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        servo_pwm_chan #(
            .SEL_W      (SEL_W),
            .CNT_W      (CNT_W),
            .MIN_TICKS  (MIN_TICKS),
`ifdef SERVO_RAMP_EN
            .STEP_TICKS (us2ticks(STEP_US, CLK_HZ)),
`endif
            .MAX_TICKS  (MAX_TICKS)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .boundary (boundary),
            .count    (cnt_q),
            .sel      (sel[i*SEL_W +: SEL_W]),
            .servo    (servo[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: 100-tick frames, widths 10/20/30/40 ticks.
// Expected widths follow SERVO_RAMP_EN (5-tick slew) when it is defined.
module tb_servo_pwm_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [1:0] servo;
    logic       frame_start;
    logic [1:0] busy;

    int checks = 0;
    int failures = 0;
    int cur [2];
    int wtab [4] = '{10, 20, 30, 40};

    servo_pwm_multi #(
        .CLK_HZ    (1_000_000),
        .CHANNELS  (2),
        .SEL_W     (2),
        .PERIOD_US (100),
        .MIN_US    (10),
        .MAX_US    (40),
        .STEP_US   (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sel         (sel),
        .servo       (servo),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nextw(input int c, input int t);
`ifdef SERVO_RAMP_EN
        if (t > c + 5) return c + 5;
        if (t < c - 5) return c - 5;
        return t;
`else
        return t;
`endif
    endfunction

    task automatic wait_fs(input string tag, output int n);
        n = 0;
        while (!frame_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, frame_start}, 32'd1);
    endtask

    // Entered at the negedge of a frame_start cycle; leaves at the next one.
    task automatic run_frame(input string tag, input int chg_at, input logic [3:0] nsel);
        int h0;
        int h1;
        int fs_mid;
        logic [1:0] bz;
        h0 = 0;
        h1 = 0;
        fs_mid = 0;
        bz = 2'bxx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            h0 += int'(servo[0]);
            h1 += int'(servo[1]);
            if (i < 100 && frame_start) fs_mid++;
            if (i == 90) bz = busy;
            if (i == chg_at) sel = nsel;
        end
        check({tag, "_w0"}, h0, cur[0]);
        check({tag, "_w1"}, h1, cur[1]);
        check({tag, "_busy0"}, {31'd0, bz[0]}, (cur[0] != wtab[sel[1:0]]) ? 32'd1 : 32'd0);
        check({tag, "_busy1"}, {31'd0, bz[1]}, (cur[1] != wtab[sel[3:2]]) ? 32'd1 : 32'd0);
        check({tag, "_fs_mid"}, fs_mid, 0);
        check({tag, "_fs_period"}, {31'd0, frame_start}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            cur[k] = nextw(cur[k], wtab[sel[k*2 +: 2]]);
        end
    endtask

    initial begin
        int n;
        int seen;
        cur[0] = 10;
        cur[1] = 10;

        repeat (3) @(negedge clk);
        check("rst_servo", {30'd0, servo}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_busy", {30'd0, busy}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 4'b1100;
        enable = 1'b1;
        @(negedge clk);
        check("en_fs_latency", {31'd0, frame_start}, 32'd1);
        check("en_servo_first", {30'd0, servo}, 32'd0);

        run_frame("t2f1", 0, sel);
        run_frame("t2f2", 0, sel);
        run_frame("t2f3", 0, sel);

        run_frame("t3mid", 50, 4'b1110);
        run_frame("t3next", 0, sel);

        run_frame("t4pre", 1, 4'b1100);
        for (int f = 0; f < 4; f++) run_frame("t4settle", 0, sel);
        run_frame("t4ramp", 1, 4'b1111);
        for (int f = 0; f < 7; f++) run_frame("t4ramp", 0, sel);

        run_frame("t6down", 1, 4'b1101);
        run_frame("t6down2", 0, sel);
        run_frame("t6up", 1, 4'b1111);
        run_frame("t6up2", 0, sel);
        run_frame("t6up3", 0, sel);

        repeat (5) @(negedge clk);
        check("t5_servo_hi", {30'd0, servo}, 32'd3);
        enable = 1'b0;
        @(negedge clk);
        check("t5_servo_off", {30'd0, servo}, 32'd0);
        check("t5_no_fs", {31'd0, frame_start}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_start || servo != 2'b00) seen++;
        end
        check("t5_idle_quiet", seen, 0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_reen_fs", {31'd0, frame_start}, 32'd1);
        run_frame("t5frame", 0, sel);

        sel = 4'b1100;
        @(negedge clk);
        @(negedge clk);
        check("t1_pre_servo", {31'd0, servo[0]}, 32'd1);
        check("t1_pre_busy", {31'd0, busy[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_servo", {30'd0, servo}, 32'd0);
        check("t1_async_fs", {31'd0, frame_start}, 32'd0);
        check("t1_async_busy", {30'd0, busy}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        sel = 4'b0000;
        cur[0] = 10;
        cur[1] = 10;
        @(negedge clk);
        wait_fs("post_rst_fs", n);
        check("post_rst_fs_lat", n, 0);
        run_frame("post_rst", 0, sel);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
